// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 single-path delay-feedback FFT stage.
// It decides which incoming samples the stage accepts and drives the delay-line
// shift, the butterfly/bypass select and the twiddle address. It also tracks
// frame alignment, produces output valid/sop after the butterfly latency, and
// drains the delay line when a flush is requested.
module fft_sdf_stage_ctrl #(
    parameter int N          = 1024,
    parameter int STAGE      = 0,
    parameter int BF_LATENCY = 3,
    parameter int TW_AW      = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             flush_req,
    output logic             shift_en,
    output logic             sel_bf,
    output logic [TW_AW-1:0] tw_addr,
    output logic             out_valid,
    output logic             out_sop,
    output logic             busy,
    output logic             frame_err
);

    // Delay depth of this stage; a block is 2*D samples and a frame is N samples.
    localparam int D  = N >> (STAGE + 1);
    localparam int BW = $clog2(2 * D);
    localparam int FW = $clog2(N);

    localparam logic [BW-1:0] B_HALF = BW'(D);
    localparam logic [BW-1:0] B_LAST = BW'(D - 1);
    localparam logic [FW-1:0] F_SOP  = FW'(D);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [BW-1:0] bcnt;
    logic [FW-1:0] fcnt;

    logic [BF_LATENCY:0] vld_pipe;
    logic [BF_LATENCY:0] sop_pipe;

    logic             accept;
    logic             resync;
    logic             err;
    logic             tag_out;
    logic             tag_sop;
    logic             sample_bf;
    logic [TW_AW-1:0] tw_calc;

    // Decide whether this cycle accepts a sample, what that sample's attributes are and where the FSM goes next.
    always_comb begin
        accept     = 1'b0;
        resync     = 1'b0;
        err        = 1'b0;
        tag_out    = 1'b0;
        tag_sop    = 1'b0;
        sample_bf  = 1'b0;
        next_state = state;
        tw_calc    = TW_AW'(bcnt - B_HALF) << STAGE;
        case (state)
            IDLE: begin
                if (in_valid && in_sop) begin
                    accept     = 1'b1;
                    next_state = (D == 1) ? RUN : FILL;
                end
            end
            FILL, RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_sop && (fcnt != '0)) begin
                        resync     = 1'b1;
                        err        = 1'b1;
                        next_state = (D == 1) ? RUN : FILL;
                    end else if (state == FILL) begin
                        if (bcnt == B_LAST) begin
                            next_state = RUN;
                        end
                    end else begin
                        tag_out   = 1'b1;
                        tag_sop   = (fcnt == F_SOP);
                        sample_bf = (bcnt >= B_HALF);
                    end
                end else if (state == RUN && flush_req && bcnt == '0 && fcnt == '0) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                accept  = 1'b1;
                tag_out = 1'b1;
                err     = in_valid;
                if (bcnt == B_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM, sample counters and the datapath control outputs, all registered one cycle after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcnt      <= '0;
            fcnt      <= '0;
            shift_en  <= 1'b0;
            sel_bf    <= 1'b0;
            tw_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= next_state;
            shift_en  <= accept;
            frame_err <= err;
            if (accept) begin
                sel_bf  <= sample_bf;
                tw_addr <= sample_bf ? tw_calc : '0;
                if (resync || state == IDLE) begin
                    bcnt <= BW'(1);
                    fcnt <= FW'(1);
                end else if (next_state == IDLE) begin
                    bcnt <= '0;
                    fcnt <= '0;
                end else begin
                    bcnt <= bcnt + 1'b1;
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Carry output valid/sop through the butterfly latency; a resync kills everything still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sop_pipe <= '0;
        end else if (resync) begin
            vld_pipe <= '0;
            sop_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[BF_LATENCY-1:0], accept & tag_out};
            sop_pipe <= {sop_pipe[BF_LATENCY-1:0], accept & tag_sop};
        end
    end

    assign out_valid = vld_pipe[BF_LATENCY];
    assign out_sop   = sop_pipe[BF_LATENCY];
    assign busy      = (state != IDLE);

endmodule
